max_pool_2x2: RTL and testbench

Streaming 2×2, stride-2 max-pooling stage that sits directly downstream of the ReLU activation in the CNN datapath. It accepts one signed activation per valid cycle in raster order (row-major, IMG_W × IMG_H feature map) and emits one pooled value per completed 2×2 window. A single line buffer of IMG_W/2 entries holds partial maxima from the even row. The block is fully pipelined with no backpressure.

---
 rtl/max_pool_2x2_if.sv | 27 ++
 rtl/max_pool_2x2.sv | 108 ++++++++++
 tb/tb_max_pool_2x2.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_if.sv
// Pixel stream into the 2x2 max-pool stage and pooled stream out of it.
// The master side drives pixels; the slave side (the pooling block) returns results.
interface max_pool_2x2_if #(
    parameter int In_d_W = 18
) ();
    logic                     in_valid;
    logic signed [In_d_W-1:0] A;
    logic signed [In_d_W-1:0] Y;
    logic                     out_valid;
    logic                     frame_done;

    modport master (
        output in_valid,
        output A,
        input  Y,
        input  out_valid,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  A,
        output Y,
        output out_valid,
        output frame_done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 signed max-pool on a raster-order feature map.
// Even rows fold pixel pairs into a half-width line buffer; odd rows complete the window.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ROW_EVEN | top row of a window pair: pair maxima go to the line buffer
//   ROW_ODD  | bottom row: pair maxima merge with the line buffer -> Y
module max_pool_2x2 #(
    parameter int In_d_W = 18,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic          clk,
    input  logic          clr,
    max_pool_2x2_if.slave pool
);
    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_t;

    row_state_t               state;
    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic signed [In_d_W-1:0] h;
    logic signed [In_d_W-1:0] y_q;
    logic                     out_valid_q;
    logic                     frame_done_q;

    logic signed [In_d_W-1:0] linebuf [LB_D];

    logic                     col_last;
    logic                     row_last;
    logic                     odd_col;
    logic [LB_AW-1:0]         lb_idx;
    logic signed [In_d_W-1:0] pair_max;
    logic signed [In_d_W-1:0] win_max;

    function automatic logic signed [In_d_W-1:0] smax(
        input logic signed [In_d_W-1:0] a,
        input logic signed [In_d_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign odd_col  = col[0];
    assign lb_idx   = LB_AW'(col >> 1);
    assign pair_max = smax(h, pool.A);
    assign win_max  = smax(linebuf[lb_idx], pair_max);

    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= ROW_EVEN;
            col          <= '0;
            row          <= '0;
            h            <= '0;
            y_q          <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (pool.in_valid) begin
                if (!odd_col) begin
                    h <= pool.A;
                end else if (state == ROW_ODD) begin
                    y_q          <= win_max;
                    out_valid_q  <= 1'b1;
                    frame_done_q <= row_last && col_last;
                end

                if (col_last) begin
                    col <= '0;
                    // IMG_H is even, so the parity FSM stays aligned with row[0] across frame wrap.
                    state <= (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
                    if (row_last) begin
                        row <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffer needs no reset: every odd-row read is preceded by an even-row write.
    always_ff @(posedge clk) begin
        if (!clr && pool.in_valid && odd_col && (state == ROW_EVEN)) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    assign pool.Y          = y_q;
    assign pool.out_valid  = out_valid_q;
    assign pool.frame_done = frame_done_q;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Self-checking bench for max_pool_2x2: frame-store reference model feeds a scoreboard queue.
module tb_max_pool_2x2;
    localparam int W = 18;
    localparam int IW = 4;
    localparam int IH = 4;

    typedef struct {
        logic signed [W-1:0] y;
        logic                fd;
    } exp_t;

    logic clk;
    logic clr;
    max_pool_2x2_if #(.In_d_W(W)) bus ();

    max_pool_2x2 #(.In_d_W(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk (clk),
        .clr (clr),
        .pool(bus)
    );

    int checks = 0;
    int errors = 0;

    exp_t                q[$];
    logic signed [W-1:0] obs[$];
    int                  fd_count = 0;
    logic signed [W-1:0] fb [IH][IW];
    int                  m_col = 0;
    int                  m_row = 0;
    logic                prev_iv = 1'b0;
    logic                prev_ov = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) prev_iv <= bus.in_valid && !clr;

    always @(negedge clk) begin
        if (!clr && bus.out_valid) begin
            check("out_after_valid", prev_iv, 1);
            check("no_back_to_back", prev_ov, 0);
            obs.push_back(bus.Y);
            if (bus.frame_done) fd_count++;
            if (q.size() == 0) begin
                check("sb_nonempty", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("Y", bus.Y, e.y);
                check("frame_done", bus.frame_done, e.fd);
            end
        end else if (!clr && bus.frame_done) begin
            check("fd_without_ov", bus.frame_done, 0);
        end
        prev_ov = bus.out_valid && !clr;
    end

    // Reference: store the whole frame, emit the window max on its bottom-right pixel.
    task automatic model_pixel(input logic signed [W-1:0] a);
        exp_t e;
        logic signed [W-1:0] m;
        fb[m_row][m_col] = a;
        if (m_row[0] && m_col[0]) begin
            m = fb[m_row-1][m_col-1];
            if (fb[m_row-1][m_col] > m) m = fb[m_row-1][m_col];
            if (fb[m_row][m_col-1] > m) m = fb[m_row][m_col-1];
            if (a > m) m = a;
            e.y  = m;
            e.fd = (m_row == IH-1) && (m_col == IW-1);
            q.push_back(e);
        end
        m_col++;
        if (m_col == IW) begin
            m_col = 0;
            m_row = (m_row + 1) % IH;
        end
    endtask

    task automatic pix(input logic v, input logic signed [W-1:0] a);
        bus.in_valid = v;
        bus.A        = a;
        if (v) model_pixel(a);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, '0);
    endtask

    task automatic pulse_clr();
        idle(2);
        clr          = 1'b1;
        bus.in_valid = 1'b0;
        q.delete();
        m_col = 0;
        m_row = 0;
        @(negedge clk);
        clr = 1'b0;
        check("rst_Y", bus.Y, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_frame_done", bus.frame_done, 0);
    endtask

    task automatic expect_obs(input string tag, input int exp_vals[$], input int exp_fd);
        idle(3);
        check({tag, "_count"}, obs.size(), exp_vals.size());
        for (int i = 0; i < exp_vals.size() && i < obs.size(); i++)
            check(tag, obs[i], exp_vals[i]);
        check({tag, "_fd_count"}, fd_count, exp_fd);
        check({tag, "_sb_drained"}, q.size(), 0);
        obs.delete();
        fd_count = 0;
    endtask

    initial begin
        logic signed [W-1:0] sframe [16];
        clr          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        @(negedge clk);
        pulse_clr();

        // Basic frame with explicit latency check on the (row 1, col 1) pixel.
        for (int i = 1; i <= 16; i++) begin
            pix(1'b1, W'(i));
            if (i == 5) check("lat_before", bus.out_valid, 0);
            if (i == 6) begin
                check("lat_ov", bus.out_valid, 1);
                check("lat_Y", bus.Y, 6);
            end
            if (i == 7) check("Y_hold", bus.Y, 6);
        end
        expect_obs("basic", '{6, 8, 14, 16}, 1);

        // Signed windows including full-scale extremes.
        sframe = '{-18'sd5, -18'sd3, -18'sd1, 18'sd0,
                   -18'sd9, -18'sd7, -18'sd2, -18'sd4,
                   -18'sd131072, 18'sd131071, -18'sd131072, -18'sd131072,
                   -18'sd131072, -18'sd131072, -18'sd131072, -18'sd131072};
        for (int i = 0; i < 16; i++) pix(1'b1, sframe[i]);
        expect_obs("signed", '{-3, 0, 131071, -131072}, 1);

        // Random stalls between pixels.
        for (int i = 1; i <= 16; i++) begin
            pix(1'b1, W'(i));
            idle($urandom_range(0, 2));
        end
        expect_obs("stall", '{6, 8, 14, 16}, 1);

        // Mid-frame clear: the pre-clear window of 100s is flushed before the clear.
        for (int i = 0; i < 7; i++) pix(1'b1, 18'sd100);
        pulse_clr();
        obs.delete();
        fd_count = 0;
        for (int i = 1; i <= 16; i++) pix(1'b1, W'(i));
        expect_obs("clr_mid", '{6, 8, 14, 16}, 1);

        // Back-to-back frames, no idle cycle at the wrap.
        for (int i = 1; i <= 16; i++) pix(1'b1, W'(i));
        for (int i = 16; i >= 1; i--) pix(1'b1, W'(i));
        expect_obs("b2b", '{6, 8, 14, 16, 16, 14, 8, 6}, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
